cpu_run_controller: RTL and testbench

//  Synthesizable run sequencer for the mips_cpu_harvard bench and FPGA harness.
//  On a start pulse it does three things:
//  - holds the CPU in reset for a programmable time, then releases it;
//  - drives clock_enable with an optional periodic stall pattern, and counts

---
 rtl/cpu_run_controller_pkg.sv | 25 ++
 rtl/cpu_run_controller_if.sv | 40 ++++
 rtl/cpu_run_controller_stall_pattern_gen.sv | 42 ++++
 rtl/cpu_run_controller.sv | 148 ++++++++++++++
 tb/tb_cpu_run_controller.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_run_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_tb_pkg : shared types and widths for the CPU run controller          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package cpu_tb_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 100000;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HOLD_RESET = 3'd1,
    RUN        = 3'd2,
    DONE       = 3'd3,
    TIMEOUT    = 3'd4
  } run_state_t;

  // Counter width able to hold TIMEOUT_CYCLES itself.
  function automatic int cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_run_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_run_controller_if : harness/CPU-facing signal bundle                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface cpu_run_controller_if #(
  parameter int DATA_W = cpu_tb_pkg::DATA_W_DEF,
  parameter int CW     = cpu_tb_pkg::cnt_width(cpu_tb_pkg::TIMEOUT_DEF)
);

  logic              start;
  logic              stall_req;
  logic              check_en;
  logic [DATA_W-1:0] expected_v0;
  logic              active;
  logic [DATA_W-1:0] register_v0;
  logic              cpu_reset;
  logic              clock_enable;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timed_out;
  logic [DATA_W-1:0] result_v0;
  logic [CW-1:0]     cycle_count;
  logic [CW-1:0]     en_count;

  modport slave (
    input  start, stall_req, check_en, expected_v0, active, register_v0,
    output cpu_reset, clock_enable, busy, done, pass, timed_out,
           result_v0, cycle_count, en_count
  );

  modport master (
    output start, stall_req, check_en, expected_v0, active, register_v0,
    input  cpu_reset, clock_enable, busy, done, pass, timed_out,
           result_v0, cycle_count, en_count
  );

endinterface
`default_nettype wire

// File: rtl/cpu_run_controller_stall_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stall_pattern_gen : periodic stall request, one of every PERIOD cycles   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module stall_pattern_gen #(
  parameter int PERIOD = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic stall
);

  generate
    if (PERIOD == 0) begin : g_no_stall
      logic w_unused;
      assign w_unused = ^{clk, reset, en};
      assign stall    = 1'b0;
    end else begin : g_phase
      localparam int            PW   = $clog2(PERIOD);
      localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);

      logic [PW-1:0] r_phase;

      // Phase restarts at zero whenever en drops, so every run sees the same pattern.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_phase <= '0;
        end else if (!en || (r_phase == LAST)) begin
          r_phase <= '0;
        end else begin
          r_phase <= r_phase + PW'(1);
        end
      end

      assign stall = en && (r_phase == LAST);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/cpu_run_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_run_controller : CPU reset/clock-enable sequencer with result check  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cpu_run_controller
  import cpu_tb_pkg::*;
#(
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int STALL_PERIOD   = 0,
  parameter int DATA_W         = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  cpu_run_controller_if.slave bus
);

  localparam int               CW       = cnt_width(TIMEOUT_CYCLES);
  localparam int               RCW      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RCW-1:0]   RST_LOAD = RCW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0]    TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_MAX  = '1;

  run_state_t        r_state;
  logic [RCW-1:0]    r_rst_cnt;
  logic              r_cpu_reset;
  logic              r_clock_enable;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_timed_out;
  logic              r_seen_active;
  logic [DATA_W-1:0] r_result_v0;
  logic [CW-1:0]     r_cycle_count;
  logic [CW-1:0]     r_en_count;

  logic w_complete;
  logic w_timeout;
  logic w_run_next;
  logic w_pattern_stall;
  logic w_ce_next;

  assign w_complete = r_seen_active && !bus.active;
  assign w_timeout  = (r_cycle_count == TO_LAST);
  // High in the cycle before each RUN cycle; outputs are computed one cycle ahead.
  assign w_run_next = ((r_state == HOLD_RESET) && (r_rst_cnt == '0)) ||
                      ((r_state == RUN) && !w_complete && !w_timeout);
  assign w_ce_next  = !bus.stall_req && !w_pattern_stall;

  stall_pattern_gen #(
    .PERIOD (STALL_PERIOD)
  ) u_stall_pattern_gen (
    .clk    (clk),
    .reset  (reset),
    .en     (w_run_next),
    .stall  (w_pattern_stall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_rst_cnt      <= '0;
      r_cpu_reset    <= 1'b1;
      r_clock_enable <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_timed_out    <= 1'b0;
      r_seen_active  <= 1'b0;
      r_result_v0    <= '0;
      r_cycle_count  <= '0;
      r_en_count     <= '0;
    end else begin
      case (r_state)
        IDLE, DONE, TIMEOUT: begin
          if (bus.start) begin
            r_state        <= HOLD_RESET;
            r_rst_cnt      <= RST_LOAD;
            r_cpu_reset    <= 1'b1;
            r_clock_enable <= 1'b1;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_timed_out    <= 1'b0;
            r_seen_active  <= 1'b0;
            r_result_v0    <= '0;
            r_cycle_count  <= '0;
            r_en_count     <= '0;
          end
        end
        HOLD_RESET: begin
          if (r_rst_cnt == '0) begin
            r_state        <= RUN;
            r_cpu_reset    <= 1'b0;
            r_clock_enable <= w_ce_next;
          end else begin
            r_rst_cnt <= r_rst_cnt - RCW'(1);
          end
        end
        RUN: begin
          if (r_cycle_count != CNT_MAX) begin
            r_cycle_count <= r_cycle_count + CW'(1);
          end
          if (r_clock_enable && (r_en_count != CNT_MAX)) begin
            r_en_count <= r_en_count + CW'(1);
          end
          if (bus.active) begin
            r_seen_active <= 1'b1;
          end
          // Completion takes priority over a coincident timeout.
          if (w_complete) begin
            r_state        <= DONE;
            r_result_v0    <= bus.register_v0;
            r_pass         <= !bus.check_en || (bus.register_v0 == bus.expected_v0);
            r_clock_enable <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b1;
          end else if (w_timeout) begin
            r_state        <= TIMEOUT;
            r_pass         <= 1'b0;
            r_timed_out    <= 1'b1;
            r_clock_enable <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b1;
          end else begin
            r_clock_enable <= w_ce_next;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_reset    = r_cpu_reset;
  assign bus.clock_enable = r_clock_enable;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.pass         = r_pass;
  assign bus.timed_out    = r_timed_out;
  assign bus.result_v0    = r_result_v0;
  assign bus.cycle_count  = r_cycle_count;
  assign bus.en_count     = r_en_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_run_controller : scoreboard bench, two controller configurations  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cpu_run_controller;
  import cpu_tb_pkg::*;

  localparam int TO_A = 16;
  localparam int TO_B = 64;
  localparam int CWA  = cnt_width(TO_A);
  localparam int CWB  = cnt_width(TO_B);

  typedef struct packed {
    logic        pass;
    logic        to;
    logic [31:0] v0;
    logic [15:0] cyc;
    logic [15:0] en;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];

  int run_cyc_a = 0;
  int act_len_a = 0;
  int run_cyc_b = 0;
  int act_len_b = 0;
  bit stall_win_b = 1'b0;
  logic done_prev_a = 1'b0;
  logic done_prev_b = 1'b0;

  cpu_run_controller_if #(.DATA_W(32), .CW(CWA)) ia ();
  cpu_run_controller_if #(.DATA_W(32), .CW(CWB)) ib ();

  cpu_run_controller #(
    .RESET_CYCLES(4), .TIMEOUT_CYCLES(TO_A), .STALL_PERIOD(0), .DATA_W(32)
  ) u_dut_a (
    .clk(clk), .reset(rst_n), .bus(ia)
  );

  cpu_run_controller #(
    .RESET_CYCLES(4), .TIMEOUT_CYCLES(TO_B), .STALL_PERIOD(4), .DATA_W(32)
  ) u_dut_b (
    .clk(clk), .reset(rst_n), .bus(ib)
  );

  // CPU model: active for the first act_len RUN cycles, then falls.
  always @(posedge clk) begin
    if (ia.cpu_reset) run_cyc_a <= 0;
    else if (ia.busy) run_cyc_a <= run_cyc_a + 1;
    if (ib.cpu_reset) run_cyc_b <= 0;
    else if (ib.busy) run_cyc_b <= run_cyc_b + 1;
  end

  assign ia.active    = !ia.cpu_reset && ia.busy && (run_cyc_a < act_len_a);
  assign ib.active    = !ib.cpu_reset && ib.busy && (run_cyc_b < act_len_b);
  // Requests in RUN cycles 4..6 suppress the enable of cycles 5..7.
  assign ib.stall_req = stall_win_b && ib.busy && !ib.cpu_reset &&
                        (run_cyc_b >= 3) && (run_cyc_b <= 5);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk_exp(input logic p, input logic t, input logic [31:0] v,
                                  input int c, input int e);
    exp_t x;
    x.pass = p;
    x.to   = t;
    x.v0   = v;
    x.cyc  = 16'(c);
    x.en   = 16'(e);
    return x;
  endfunction

  // Scoreboard monitor: each rising done pops one expected completion.
  always @(negedge clk) begin
    if (ia.done && !done_prev_a) begin
      if (exp_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_unexpected_done: got done=1, expected no completion");
      end else begin
        check("a_pass",      ia.pass,         exp_a[0].pass);
        check("a_timed_out", ia.timed_out,    exp_a[0].to);
        check("a_result_v0", ia.result_v0,    exp_a[0].v0);
        check("a_cycles",    ia.cycle_count,  exp_a[0].cyc);
        check("a_en_cycles", ia.en_count,     exp_a[0].en);
        check("a_ce_frozen", ia.clock_enable, 1'b0);
        check("a_cpu_reset", ia.cpu_reset,    1'b0);
        exp_a.delete(0);
      end
    end
    if (ib.done && !done_prev_b) begin
      if (exp_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected_done: got done=1, expected no completion");
      end else begin
        check("b_pass",      ib.pass,         exp_b[0].pass);
        check("b_timed_out", ib.timed_out,    exp_b[0].to);
        check("b_result_v0", ib.result_v0,    exp_b[0].v0);
        check("b_cycles",    ib.cycle_count,  exp_b[0].cyc);
        check("b_en_cycles", ib.en_count,     exp_b[0].en);
        check("b_ce_frozen", ib.clock_enable, 1'b0);
        exp_b.delete(0);
      end
    end
    done_prev_a <= ia.done;
    done_prev_b <= ib.done;
  end

  task automatic pulse_start_a();
    @(posedge clk); #1 ia.start = 1'b1;
    @(posedge clk); #1 ia.start = 1'b0;
  endtask

  task automatic pulse_start_b();
    @(posedge clk); #1 ib.start = 1'b1;
    @(posedge clk); #1 ib.start = 1'b0;
  endtask

  task automatic program_a(input int len, input logic [31:0] v0, input logic [31:0] expv,
                           input logic chk);
    act_len_a = len;
    ia.register_v0 = v0;
    ia.expected_v0 = expv;
    ia.check_en    = chk;
  endtask

  task automatic wait_done_a(input int bound);
    int n;
    n = 0;
    while (!ia.done && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("a_done_reached", ia.done, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_done_b(input int bound);
    int n;
    n = 0;
    while (!ib.done && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("b_done_reached", ib.done, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    ia.start = 1'b0; ia.stall_req = 1'b0; ia.check_en = 1'b1;
    ia.expected_v0 = '0; ia.register_v0 = '0;
    ib.start = 1'b0; ib.check_en = 1'b1;
    ib.expected_v0 = '0; ib.register_v0 = '0;

    // Reset state
    @(negedge clk);
    check("rst_cpu_reset",   ia.cpu_reset,    1'b1);
    check("rst_ce",          ia.clock_enable, 1'b0);
    check("rst_busy",        ia.busy,         1'b0);
    check("rst_done",        ia.done,         1'b0);
    check("rst_pass",        ia.pass,         1'b0);
    check("rst_timed_out",   ia.timed_out,    1'b0);
    check("rst_result",      ia.result_v0,    0);
    check("rst_cycles",      ia.cycle_count,  0);
    check("rst_en_cycles",   ia.en_count,     0);
    check("rst_b_cpu_reset", ib.cpu_reset,    1'b1);
    @(posedge clk); #2 rst_n = 1'b1;

    // Reset hold length, then a 10-cycle program returning 2A
    program_a(10, 32'h2A, 32'h2A, 1'b1);
    exp_a.push_back(mk_exp(1'b1, 1'b0, 32'h2A, 11, 11));
    pulse_start_a();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_cpu_reset_hold", ia.cpu_reset, 1'b1);
      check("t1_ce_hold", ia.clock_enable, 1'b1);
    end
    @(negedge clk);
    check("t1_cpu_reset_release", ia.cpu_reset, 1'b0);
    n = 0;
    while (ia.busy && n < 40) begin
      check("t1_ce_run", ia.clock_enable, 1'b1);
      @(negedge clk);
      n++;
    end
    wait_done_a(10);

    // Wrong expected value, then checking disabled
    program_a(10, 32'h2A, 32'h2B, 1'b1);
    exp_a.push_back(mk_exp(1'b0, 1'b0, 32'h2A, 11, 11));
    pulse_start_a();
    wait_done_a(40);
    program_a(10, 32'h2A, 32'h2B, 1'b0);
    exp_a.push_back(mk_exp(1'b1, 1'b0, 32'h2A, 11, 11));
    pulse_start_a();
    wait_done_a(40);

    // Timeout, then completion on the last budget cycle
    program_a(1000, 32'h2A, 32'h2A, 1'b1);
    exp_a.push_back(mk_exp(1'b0, 1'b1, 32'h0, 16, 16));
    pulse_start_a();
    wait_done_a(40);
    program_a(15, 32'h2A, 32'h2A, 1'b1);
    exp_a.push_back(mk_exp(1'b1, 1'b0, 32'h2A, 16, 16));
    pulse_start_a();
    wait_done_a(40);

    // Asynchronous reset in the middle of a run
    program_a(10, 32'h2A, 32'h2A, 1'b1);
    pulse_start_a();
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_cpu_reset", ia.cpu_reset,   1'b1);
    check("t6_async_done",      ia.done,        1'b0);
    check("t6_async_busy",      ia.busy,        1'b0);
    check("t6_async_cycles",    ia.cycle_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // start during RUN is ignored
    exp_a.push_back(mk_exp(1'b1, 1'b0, 32'h2A, 11, 11));
    pulse_start_a();
    repeat (7) @(negedge clk);
    pulse_start_a();
    @(negedge clk);
    check("t6_start_in_run_cpu_reset", ia.cpu_reset, 1'b0);
    check("t6_start_in_run_busy",      ia.busy,      1'b1);
    wait_done_a(40);

    // start from DONE re-runs with cleared counters
    program_a(10, 32'h0000_1234, 32'h0000_1234, 1'b1);
    exp_a.push_back(mk_exp(1'b1, 1'b0, 32'h1234, 11, 11));
    pulse_start_a();
    @(negedge clk);
    check("t6_rerun_cycles_cleared", ia.cycle_count, 0);
    check("t6_rerun_en_cleared",     ia.en_count,    0);
    check("t6_rerun_done_cleared",   ia.done,        1'b0);
    check("t6_rerun_result_cleared", ia.result_v0,   0);
    wait_done_a(40);

    // Periodic stall pattern, period 4, 20 RUN cycles
    act_len_b = 19;
    ib.register_v0 = 32'h2A;
    ib.expected_v0 = 32'h2A;
    ib.check_en    = 1'b1;
    exp_b.push_back(mk_exp(1'b1, 1'b0, 32'h2A, 20, 15));
    pulse_start_b();
    n = 0;
    while (ib.cpu_reset && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t4_b_released", ib.cpu_reset, 1'b0);
    n = 0;
    while (ib.busy && n < 40) begin
      check("t4_ce_pattern", ib.clock_enable, ((run_cyc_b % 4) != 3));
      @(negedge clk);
      n++;
    end
    wait_done_b(10);

    // External stall for three cycles on top of the pattern
    stall_win_b = 1'b1;
    exp_b.push_back(mk_exp(1'b1, 1'b0, 32'h2A, 20, 12));
    pulse_start_b();
    wait_done_b(60);
    stall_win_b = 1'b0;

    repeat (3) @(negedge clk);
    check("a_scoreboard_drained", exp_a.size(), 0);
    check("b_scoreboard_drained", exp_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
